// File: rtl/bus_arbiter2.sv
// Round-robin share of one 8-bit slave bus between two masters (m0 CPU, m1 DMA/loader).
// Access = 3+ cycles: grant/latch, wait for s_ready (or timeout), one-cycle ack; masters hold requests until ack.
module bus_arbiter2 #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_write,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_write,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_write,
    output logic              s_read,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        grant
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             req0;
    logic             req1;
    logic             any_req;
    logic             pick1;
    logic             sel_write;
    logic             sel_read;
    logic             timeout_hit;
    logic             finish;
    logic             last_grant;   // 0 = m0 owned the last access, 1 = m1
    logic [CNT_W-1:0] cnt;

    always_comb begin
        req0        = m0_write | m0_read;
        req1        = m1_write | m1_read;
        any_req     = req0 | req1;
        // m1 wins alone, or under contention when m0 had the previous turn
        pick1       = req1 & (~req0 | ~last_grant);
        sel_write   = pick1 ? m1_write : m0_write;
        sel_read    = pick1 ? m1_read  : m0_read;
        timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);
        finish      = s_ready | timeout_hit;
        state_nxt   = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (finish)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_write    <= 1'b0;
            s_read     <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            cnt        <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        s_addr     <= pick1 ? m1_addr  : m0_addr;
                        s_wdata    <= pick1 ? m1_wdata : m0_wdata;
                        s_write    <= sel_write;
                        s_read     <= sel_read & ~sel_write;
                        grant      <= pick1 ? 2'b10 : 2'b01;
                        last_grant <= pick1;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        // s_ready has priority, so err only when the slave never answered
                        s_write <= 1'b0;
                        s_read  <= 1'b0;
                        grant   <= 2'b00;
                        if (grant[1]) begin
                            m1_ack <= 1'b1;
                            m1_err <= ~s_ready;
                            if (s_read) m1_rdata <= s_ready ? s_rdata : '1;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= ~s_ready;
                            if (s_read) m0_rdata <= s_ready ? s_rdata : '1;
                        end
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed checks of bus_arbiter2: latency, read capture, round-robin, timeout, reset abort, write priority.
module tb_bus_arbiter2;

    logic       clk;
    logic       rst;
    logic       m0_write, m0_read, m1_write, m1_read;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic       s_write, s_read, s_ready;
    logic [7:0] s_addr, s_wdata, s_rdata;
    logic [1:0] grant;

    int vectors = 0;
    int miscompares = 0;

    bus_arbiter2 #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_write(m0_write), .m0_read(m0_read), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_write(m1_write), .m1_read(m1_read), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_write(s_write), .s_read(s_read), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_write = 0; m0_read = 0; m0_addr = 0; m0_wdata = 0;
        m1_write = 0; m1_read = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0; s_ready = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_s_write", s_write, 0);
        chk("rst_s_read", s_read, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_err", m0_err, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        #9 rst = 1'b1;
        tick();
        chk("idle_grant", grant, 0);

        // 1: m0 write, zero-wait slave
        m0_addr = 8'h80; m0_wdata = 8'hE0; m0_write = 1; s_ready = 1;
        tick();
        chk("t1_s_write", s_write, 1);
        chk("t1_s_read", s_read, 0);
        chk("t1_s_addr", s_addr, 8'h80);
        chk("t1_s_wdata", s_wdata, 8'hE0);
        chk("t1_grant", grant, 2'b01);
        chk("t1_ack_early", m0_ack, 0);
        tick();
        chk("t1_m0_ack", m0_ack, 1);
        chk("t1_m0_err", m0_err, 0);
        chk("t1_strobe_done", s_write, 0);
        chk("t1_grant_done", grant, 0);
        m0_write = 0;
        tick();
        chk("t1_ack_one_cycle", m0_ack, 0);
        tick();
        chk("t1_idle_strobe", s_write, 0);

        // 4: m0 read times out after 15 ACCESS cycles
        m0_addr = 8'h10; m0_read = 1; s_ready = 0;
        tick();
        chk("t4_s_read", s_read, 1);
        chk("t4_s_write", s_write, 0);
        chk("t4_grant", grant, 2'b01);
        repeat (14) tick();
        chk("t4_still_access", s_read, 1);
        chk("t4_no_ack_yet", m0_ack, 0);
        tick();
        chk("t4_m0_ack", m0_ack, 1);
        chk("t4_m0_err", m0_err, 1);
        chk("t4_m0_rdata", m0_rdata, 8'hFF);
        chk("t4_s_read_done", s_read, 0);
        chk("t4_m1_ack", m1_ack, 0);
        m0_read = 0;
        tick();
        chk("t4_ack_clear", m0_ack, 0);
        chk("t4_err_clear", m0_err, 0);

        // 2: m1 read with 3 wait states
        m1_addr = 8'h80; m1_read = 1; s_rdata = 8'hA0; s_ready = 0;
        tick();
        chk("t2_s_read", s_read, 1);
        chk("t2_grant", grant, 2'b10);
        chk("t2_s_addr", s_addr, 8'h80);
        repeat (3) tick();
        chk("t2_wait_ack", m1_ack, 0);
        chk("t2_wait_strobe", s_read, 1);
        s_ready = 1;
        tick();
        chk("t2_m1_ack", m1_ack, 1);
        chk("t2_m1_rdata", m1_rdata, 8'hA0);
        chk("t2_m1_err", m1_err, 0);
        chk("t2_m0_rdata_kept", m0_rdata, 8'hFF);
        chk("t2_m0_ack", m0_ack, 0);
        m1_read = 0;
        tick();

        // 3: continuous contention alternates, m0 first
        m0_write = 1; m0_addr = 8'h01; m0_wdata = 8'h11;
        m1_write = 1; m1_addr = 8'h02; m1_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            logic is_m1;
            is_m1 = logic'(i % 2);
            tick();
            chk("t3_grant", grant, is_m1 ? 2'b10 : 2'b01);
            chk("t3_s_addr", s_addr, is_m1 ? 8'h02 : 8'h01);
            tick();
            chk("t3_m0_ack", m0_ack, !is_m1);
            chk("t3_m1_ack", m1_ack, is_m1);
            tick();
            chk("t3_idle_grant", grant, 0);
        end
        m0_write = 0; m1_write = 0;

        // 6: m0 drops request mid-access; m1 write+read becomes write only
        m1_write = 1; m1_read = 1; m1_addr = 8'h33; m1_wdata = 8'h5A;
        m0_write = 1; m0_addr = 8'h44; m0_wdata = 8'h66;
        s_ready = 0;
        tick();
        chk("t6_grant_m0", grant, 2'b01);
        chk("t6_s_addr_m0", s_addr, 8'h44);
        chk("t6_s_wdata_m0", s_wdata, 8'h66);
        m0_write = 0;
        tick();
        chk("t6_hold_strobe", s_write, 1);
        chk("t6_hold_grant", grant, 2'b01);
        s_ready = 1;
        tick();
        chk("t6_m0_ack", m0_ack, 1);
        chk("t6_m1_ack_none", m1_ack, 0);
        tick();
        tick();
        chk("t6_grant_m1", grant, 2'b10);
        chk("t6_s_write", s_write, 1);
        chk("t6_s_read", s_read, 0);
        chk("t6_s_addr_m1", s_addr, 8'h33);
        chk("t6_s_wdata_m1", s_wdata, 8'h5A);
        tick();
        chk("t6_m1_ack", m1_ack, 1);
        chk("t6_m1_rdata_kept", m1_rdata, 8'hA0);
        chk("t6_m0_ack_quiet", m0_ack, 0);
        m1_write = 0; m1_read = 0;
        tick();

        // 5: async reset mid-access
        m0_addr = 8'h55; m0_read = 1; s_ready = 0;
        tick();
        chk("t5_grant", grant, 2'b01);
        chk("t5_s_read", s_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_s_read", s_read, 0);
        chk("t5_async_grant", grant, 0);
        chk("t5_async_ack", m0_ack, 0);
        chk("t5_async_m0_rdata", m0_rdata, 0);
        chk("t5_async_m1_rdata", m1_rdata, 0);
        m0_read = 0;
        #2 rst = 1'b1;
        tick();
        chk("t5_no_ack_1", m0_ack, 0);
        chk("t5_idle_grant", grant, 0);
        tick();
        chk("t5_no_ack_2", m0_ack, 0);
        m0_write = 1; m0_addr = 8'h01; m1_write = 1; m1_addr = 8'h02; s_ready = 1;
        tick();
        chk("t5_contend_grant", grant, 2'b01);
        chk("t5_contend_addr", s_addr, 8'h01);
        tick();
        chk("t5_contend_ack", m0_ack, 1);
        m0_write = 0; m1_write = 0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
